// File: rtl/freq_meas_ctrl_pkg.sv
// Shared widths, response status codes and controller state encodings for the
// frequency-measure command path.
package freq_meas_ctrl_pkg;

  localparam int unsigned FREQ_CNT_NBIT  = 16;
  localparam int unsigned FREQ_TO_NBIT   = 8;
  localparam int unsigned FREQ_DATA_NBIT = 32;

  localparam logic [7:0] FREQ_ST_OK      = 8'h00;
  localparam logic [7:0] FREQ_ST_TIMEOUT = 8'h01;
  localparam logic [7:0] FREQ_ST_NOSIG   = 8'h02;
  localparam logic [7:0] FREQ_ST_BADCH   = 8'h03;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StArm   = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StSend  = 3'd4;

  // One status byte followed by the frequency bytes.
  function automatic int unsigned resp_nbytes(input int unsigned data_nbit);
    return 1 + data_nbit / 8;
  endfunction

endpackage

// File: rtl/freq_resp_ser.sv
// Valid/ready byte serializer: status byte, then the frequency word MSB first,
// with tx_last flagging the final byte.
module freq_resp_ser
  import freq_meas_ctrl_pkg::*;
#(
  parameter int unsigned DATA_NBIT = FREQ_DATA_NBIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [7:0]           status,
  input  logic [DATA_NBIT-1:0] freq,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_last
);

  localparam int unsigned NB      = resp_nbytes(DATA_NBIT);
  localparam int unsigned IdxNbit = $clog2(NB);
  localparam logic [IdxNbit-1:0] LastIdx = IdxNbit'(NB - 1);

  logic [DATA_NBIT-1:0] shift_q, shift_d;
  logic [IdxNbit-1:0]   idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      shift_d = freq;
      idx_d   = '0;
      valid_d = 1'b1;
      data_d  = status;
      last_d  = 1'b0;
    end else if (valid_q && tx_ready) begin
      if (idx_q == LastIdx) begin
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
        idx_d   = '0;
      end else begin
        data_d  = shift_q[DATA_NBIT-1 -: 8];
        shift_d = shift_q << 8;
        idx_d   = idx_q + 1'b1;
        last_d  = ((idx_q + 1'b1) == LastIdx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign tx_last  = last_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Command-side controller for the frequency-measure block: channel mux, start
// sequencing, no-signal watchdog and byte-stream response.
module freq_meas_ctrl
  import freq_meas_ctrl_pkg::*;
#(
  parameter int unsigned N_IO      = 8,
  parameter int unsigned SEL_NBIT  = 4,
  parameter int unsigned CNT_NBIT  = FREQ_CNT_NBIT,
  parameter int unsigned TO_NBIT   = FREQ_TO_NBIT,
  parameter int unsigned DATA_NBIT = FREQ_DATA_NBIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [SEL_NBIT-1:0]  cmd_ch,
  input  logic [CNT_NBIT-1:0]  cmd_cnt,
  input  logic [TO_NBIT-1:0]   cmd_timeout,
  input  logic [N_IO-1:0]      io_bus,
  output logic                 meas_start,
  output logic [CNT_NBIT-1:0]  meas_cnt,
  output logic [TO_NBIT-1:0]   meas_timeout,
  output logic                 meas_io,
  input  logic [DATA_NBIT-1:0] meas_freq,
  input  logic                 meas_done,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_last
);

  logic [2:0]           state_q, state_d;
  logic [SEL_NBIT-1:0]  ch_q, ch_d;
  logic [CNT_NBIT-1:0]  cnt_q, cnt_d;
  logic [TO_NBIT-1:0]   timeout_q, timeout_d;
  logic                 start_q, start_d;
  logic                 io_q, io_sel;
  logic [DATA_NBIT-1:0] wdog_q, wdog_d;
  logic [7:0]           status_q, status_d;
  logic [DATA_NBIT-1:0] freq_q, freq_d;
  logic                 load_q, load_d;
  logic                 cmd_ch_ok;
  logic                 wdog_expired;
  logic                 tx_valid_int;
  logic                 tx_last_int;

  assign cmd_ch_ok    = (cmd_ch < SEL_NBIT'(N_IO));
  assign wdog_expired = (wdog_q[DATA_NBIT-1 -: TO_NBIT] > timeout_q) || (&wdog_q);

  // Out-of-range channels match no pin and select 0.
  always_comb begin
    io_sel = 1'b0;
    for (int i = 0; i < N_IO; i++) begin
      if (ch_q == SEL_NBIT'(i)) begin
        io_sel = io_bus[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    start_d   = 1'b0;
    wdog_d    = wdog_q;
    status_d  = status_q;
    freq_d    = freq_q;
    load_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ch_d      = cmd_ch;
          cnt_d     = cmd_cnt;
          timeout_d = cmd_timeout;
          if (cmd_ch_ok) begin
            start_d = 1'b1;
            state_d = StStart;
          end else begin
            status_d = FREQ_ST_BADCH;
            freq_d   = '0;
            load_d   = 1'b1;
            state_d  = StSend;
          end
        end
      end
      StStart: begin
        wdog_d  = '0;
        state_d = StArm;
      end
      // meas_done still reflects the previous run here.
      StArm: begin
        state_d = StWait;
      end
      StWait: begin
        if (!(&wdog_q)) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (meas_done) begin
          freq_d   = meas_freq;
          status_d = (meas_freq[DATA_NBIT-1 -: TO_NBIT] > timeout_q) ? FREQ_ST_TIMEOUT
                                                                      : FREQ_ST_OK;
          load_d   = 1'b1;
          state_d  = StSend;
        end else if (wdog_expired) begin
          freq_d   = '0;
          status_d = FREQ_ST_NOSIG;
          load_d   = 1'b1;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (tx_valid_int && tx_ready && tx_last_int) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= '0;
      start_q   <= 1'b0;
      io_q      <= 1'b0;
      wdog_q    <= '0;
      status_q  <= '0;
      freq_q    <= '0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      io_q      <= io_sel;
      wdog_q    <= wdog_d;
      status_q  <= status_d;
      freq_q    <= freq_d;
      load_q    <= load_d;
    end
  end

  freq_resp_ser #(
    .DATA_NBIT (DATA_NBIT)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load_q),
    .status   (status_q),
    .freq     (freq_q),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid_int),
    .tx_data  (tx_data),
    .tx_last  (tx_last_int)
  );

  assign cmd_ready    = (state_q == StIdle) && !rst;
  assign meas_start   = start_q;
  assign meas_cnt     = cnt_q;
  assign meas_timeout = timeout_q;
  assign meas_io      = io_q;
  assign tx_valid     = tx_valid_int;
  assign tx_last      = tx_last_int;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Randomized bench for freq_meas_ctrl with a behavioural measure-block model and
// a byte scoreboard; a narrow build covers the no-signal watchdog.
module tb_freq_meas_ctrl;

  localparam int unsigned N_IO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_ch;
  logic [15:0] cmd_cnt;
  logic [7:0]  cmd_timeout;
  logic [7:0]  io_bus;
  logic        meas_start, meas_io, meas_done;
  logic [15:0] meas_cnt;
  logic [7:0]  meas_timeout;
  logic [31:0] meas_freq;
  logic        tx_valid, tx_ready, tx_last;
  logic [7:0]  tx_data;

  freq_meas_ctrl #(
    .N_IO(8), .SEL_NBIT(4), .CNT_NBIT(16), .TO_NBIT(8), .DATA_NBIT(32)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_cnt(cmd_cnt), .cmd_timeout(cmd_timeout), .io_bus(io_bus), .meas_start(meas_start),
    .meas_cnt(meas_cnt), .meas_timeout(meas_timeout), .meas_io(meas_io),
    .meas_freq(meas_freq), .meas_done(meas_done), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last)
  );

  // Narrow build: 16-bit result, 4-bit timeout.
  logic        cmd_valid_n, cmd_ready_n, meas_start_n, meas_io_n, tx_valid_n, tx_last_n;
  logic [3:0]  cmd_ch_n, cmd_timeout_n, meas_timeout_n;
  logic [15:0] cmd_cnt_n, meas_cnt_n, meas_freq_n;
  logic [7:0]  io_bus_n, tx_data_n;
  logic        meas_done_n, tx_ready_n;

  freq_meas_ctrl #(
    .N_IO(8), .SEL_NBIT(4), .CNT_NBIT(16), .TO_NBIT(4), .DATA_NBIT(16)
  ) dut_n (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_n), .cmd_ready(cmd_ready_n),
    .cmd_ch(cmd_ch_n), .cmd_cnt(cmd_cnt_n), .cmd_timeout(cmd_timeout_n), .io_bus(io_bus_n),
    .meas_start(meas_start_n), .meas_cnt(meas_cnt_n), .meas_timeout(meas_timeout_n),
    .meas_io(meas_io_n), .meas_freq(meas_freq_n), .meas_done(meas_done_n),
    .tx_valid(tx_valid_n), .tx_ready(tx_ready_n), .tx_data(tx_data_n), .tx_last(tx_last_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and transaction bookkeeping
  logic [7:0]  exp_q[$];
  bit          busy = 0;
  bit          last_acc = 0;
  bit          first_seen = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          cur_minlat = 0;
  logic [3:0]  cur_ch;
  logic [15:0] cur_cnt;
  logic [7:0]  cur_to;

  // Measure-block model and tx backpressure policy
  bit          mb_busy = 0;
  int          mb_ctr = 0;
  int          mb_delay = 0;
  logic [31:0] mb_freq = 0;
  int          bp_mode = 0;
  int          stall_cnt = 0;

  task automatic push_expected();
    logic [7:0]  st;
    logic [31:0] f;
    if (cmd_ch >= N_IO) begin
      st = 8'h03;
      f  = 32'h0;
    end else begin
      f  = mb_freq;
      st = (mb_freq[31:24] > cmd_timeout) ? 8'h01 : 8'h00;
    end
    exp_q.push_back(st);
    for (int b = 3; b >= 0; b--) exp_q.push_back(f[b*8 +: 8]);
  endtask

  task automatic tick();
    bit         acc, txh, rst_s, stalled;
    logic [7:0] data_prev, io_prev;
    bit         ch_ok;
    rst_s     = rst;
    acc       = cmd_valid && cmd_ready && !rst;
    txh       = tx_valid && tx_ready && !rst;
    stalled   = tx_valid && !tx_ready && !rst;
    data_prev = tx_data;
    io_prev   = io_bus;
    last_acc  = acc;
    if (txh) begin
      if (exp_q.size() > 0) begin
        check_eq("tx_data", tx_data, exp_q[0]);
        check_eq("tx_last", tx_last, exp_q.size() == 1);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) busy = 0;
      end
    end
    if (acc) begin
      busy       = 1;
      acc_cyc    = cyc + 1;
      first_seen = 0;
      cur_ch     = cmd_ch;
      cur_cnt    = cmd_cnt;
      cur_to     = cmd_timeout;
      cur_minlat = (cmd_ch >= N_IO) ? 2 : 4;
      push_expected();
    end
    @(negedge clk);
    cyc++;
    ch_ok = (cur_ch < N_IO);
    if (rst_s) begin
      busy = 0;
      exp_q.delete();
      check_eq("rst_tx_valid", tx_valid, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_tx_last", tx_last, 0);
      check_eq("rst_meas_start", meas_start, 0);
      check_eq("rst_meas_cnt", meas_cnt, 0);
      check_eq("rst_meas_timeout", meas_timeout, 0);
      check_eq("rst_meas_io", meas_io, 0);
    end else begin
      check_eq("meas_start", meas_start, busy && ch_ok && (cyc == acc_cyc));
      if (busy && cyc == acc_cyc) begin
        check_eq("meas_cnt", meas_cnt, cur_cnt);
        check_eq("meas_timeout", meas_timeout, cur_to);
      end
      if (busy && cyc > acc_cyc) check_eq("meas_io", meas_io, ch_ok ? io_prev[cur_ch] : 1'b0);
      if (busy && tx_valid && !first_seen) begin
        first_seen = 1;
        check_eq("latency_min", (cyc - acc_cyc + 1) >= cur_minlat, 1);
      end
      if (exp_q.size() == 0) check_eq("tx_valid_idle", tx_valid, 0);
      if (stalled) begin
        check_eq("tx_valid_hold", tx_valid, 1);
        check_eq("tx_data_hold", tx_data, data_prev);
      end
    end
    check_eq("cmd_ready", cmd_ready, !busy && !rst);
    // Measure-block model: done stays stale through ARM, then drops until the result.
    if (mb_busy) begin
      mb_ctr++;
      if (mb_ctr >= 2) begin
        if (mb_ctr - 2 >= mb_delay) begin
          meas_done = 1'b1;
          meas_freq = mb_freq;
          mb_busy   = 0;
        end else begin
          meas_done = 1'b0;
          meas_freq = $urandom;
        end
      end
    end
    if (!rst_s && meas_start) begin
      mb_busy = 1;
      mb_ctr  = 0;
    end
    io_bus = 8'($urandom);
    case (bp_mode)
      1: begin
        if (tx_valid && stall_cnt < 3) begin
          tx_ready = 1'b0;
          stall_cnt++;
        end else if (tx_valid) begin
          tx_ready  = 1'b1;
          stall_cnt = 0;
        end else begin
          tx_ready = 1'b0;
        end
      end
      2: tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b1;
    endcase
  endtask

  task automatic issue(input logic [3:0] ch, input logic [15:0] cnt, input logic [7:0] to,
                       input logic [31:0] freq, input int delay, input int bp);
    int n;
    mb_freq     = freq;
    mb_delay    = delay;
    bp_mode     = bp;
    stall_cnt   = 0;
    cmd_ch      = ch;
    cmd_cnt     = cnt;
    cmd_timeout = to;
    cmd_valid   = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    cmd_valid = 1'b0;
    check_eq("cmd_accepted", last_acc, 1);
  endtask

  task automatic run_cmd(input logic [3:0] ch, input logic [15:0] cnt, input logic [7:0] to,
                         input logic [31:0] freq, input int delay, input int bp);
    int n;
    issue(ch, cnt, to, freq, delay, bp);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check_eq("resp_complete", busy, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_ch = '0; cmd_cnt = '0; cmd_timeout = '0;
    io_bus = '0; meas_done = 1'b0; meas_freq = '0; tx_ready = 1'b1;
    cmd_valid_n = 1'b0; cmd_ch_n = '0; cmd_cnt_n = '0; cmd_timeout_n = '0;
    io_bus_n = '0; meas_done_n = 1'b0; meas_freq_n = '0; tx_ready_n = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    run_cmd(4'd2, 16'd4, 8'hFF, 32'd40, 5, 0);
    run_cmd(4'd1, 16'd7, 8'h01, 32'h0300_0000, 3, 0);
    run_cmd(4'd8, 16'd9, 8'h10, 32'hAAAA_5555, 0, 0);
    run_cmd(4'd5, 16'd2, 8'h80, 32'h8123_4567, 2, 1);

    // Abandon a measurement mid-WAIT; the late done must be ignored.
    issue(4'd3, 16'd6, 8'h20, 32'h1234_5678, 30, 0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) tick();
    run_cmd(4'd6, 16'd3, 8'h40, 32'h3F00_00FF, 4, 0);

    for (int i = 0; i < 14; i++) begin
      run_cmd(4'($urandom_range(0, 9)), 16'($urandom), 8'($urandom), $urandom,
              $urandom_range(0, 12), $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) tick();
    end
    bp_mode = 0;

    // No-signal watchdog on the narrow build.
    cmd_ch_n = 4'd3; cmd_cnt_n = 16'd5; cmd_timeout_n = 4'h1;
    check_eq("n_cmd_ready", cmd_ready_n, 1);
    cmd_valid_n = 1'b1;
    tick();
    cmd_valid_n = 1'b0;
    k = 1;
    check_eq("n_meas_start", meas_start_n, 1);
    while (!tx_valid_n && k < 9000) begin
      tick();
      k++;
    end
    check_eq("n_latency_lo", k >= 32'h2004, 1);
    check_eq("n_latency_hi", k <= 32'h2008, 1);
    for (int j = 0; j < 3; j++) begin
      check_eq("n_tx_valid", tx_valid_n, 1);
      check_eq("n_tx_data", tx_data_n, (j == 0) ? 8'h02 : 8'h00);
      check_eq("n_tx_last", tx_last_n, j == 2);
      tick();
    end
    check_eq("n_tx_valid_end", tx_valid_n, 0);
    check_eq("n_cmd_ready_end", cmd_ready_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
